tdc_interval_calc: RTL and testbench

- Downstream consumer of the delay-line fine code.
- Takes synchronized edge events with their 6-bit `fine_count`, timestamps a START and a STOP event, and computes the start-to-stop interval in fine-bin units.
- Presents each result on a valid/ready interface to the readout path.
- Handles arming, timeout when no STOP arrives, and counting of dropped events.

---
 rtl/tdc_interval_calc.sv | 221 ++++++++++++++++++++++
 tb/tb_tdc_interval_calc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_interval_calc.sv
// ---------------------------------------------------------------------------
// tdc_interval_calc
//
// Time-to-digital interval calculator. It timestamps a START and a STOP edge
// event, each carrying a 6-bit delay-line fine code, and reports the interval
// between them in fine-bin units on a valid/ready result interface.
//
// Interval = coarse * 64 + start_fine - stop_fine.
// A larger fine code means the edge happened earlier within its clock.
//
// Ports:
//   clk              system clock
//   rst_n            synchronous active-low reset
//   arm              one-cycle pulse, arms a measurement from IDLE
//   event_valid      one-cycle edge event pulse
//   event_fine       fine code of the event (0..63)
//   result_valid     result available (registered)
//   result_ready     downstream accepts the result
//   result_interval  interval in fine bins (COARSE_W+6 bits)
//   result_timeout   result is a timeout, interval is 0
//   busy             high while armed, measuring or holding a result
//   dropped_count    saturating count of events ignored while holding a result
// ---------------------------------------------------------------------------
module tdc_interval_calc #(
    parameter int COARSE_W       = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter bit AUTO_REARM     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  event_valid,
    input  logic [5:0]            event_fine,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [COARSE_W+5:0]   result_interval,
    output logic                  result_timeout,
    output logic                  busy,
    output logic [7:0]            dropped_count
);

    localparam int                IW          = COARSE_W + 6;
    localparam logic [COARSE_W-1:0] TIMEOUT_VAL = COARSE_W'(TIMEOUT_CYCLES);
    localparam logic [COARSE_W-1:0] COARSE_ONE  = COARSE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_WAIT_STOP  = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    // Saturating 8-bit increment used by the dropped-event counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [COARSE_W-1:0]   coarse_r;
    logic [COARSE_W-1:0]   coarse_s;
    logic [5:0]            start_fine_r;
    logic [5:0]            start_fine_s;
    logic                  result_valid_r;
    logic                  result_valid_s;
    logic [IW-1:0]         result_interval_r;
    logic [IW-1:0]         result_interval_s;
    logic                  result_timeout_r;
    logic                  result_timeout_s;
    logic                  busy_r;
    logic                  busy_s;
    logic [7:0]            dropped_r;
    logic [7:0]            dropped_s;
    logic [IW-1:0]         interval_calc_s;
    logic                  accept_s;

    // Coarse is always >= 1 when a STOP is taken, so the subtraction cannot
    // underflow: the smallest case is 64 + 0 - 63 = 1.
    assign interval_calc_s = {coarse_r, 6'b000000}
                           + {{COARSE_W{1'b0}}, start_fine_r}
                           - {{COARSE_W{1'b0}}, event_fine};

    assign accept_s = result_valid_r & result_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                // An event arriving together with arm is not a START.
                if (arm) begin
                    state_next_s = S_WAIT_START;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT_START: begin
                if (event_valid) begin
                    state_next_s = S_WAIT_STOP;
                end else begin
                    state_next_s = S_WAIT_START;
                end
            end
            S_WAIT_STOP: begin
                // A STOP in the timeout cycle still counts as a STOP.
                if (event_valid || (coarse_r == TIMEOUT_VAL)) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_WAIT_STOP;
                end
            end
            S_DONE: begin
                if (accept_s) begin
                    state_next_s = AUTO_REARM ? S_WAIT_START : S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Datapath and output next-value decode.
    always_comb begin
        coarse_s          = coarse_r;
        start_fine_s      = start_fine_r;
        result_valid_s    = result_valid_r;
        result_interval_s = result_interval_r;
        result_timeout_s  = result_timeout_r;
        dropped_s         = dropped_r;
        busy_s            = (state_next_s != S_IDLE);
        case (state_r)
            S_IDLE: begin
                coarse_s = coarse_r;
            end
            S_WAIT_START: begin
                if (event_valid) begin
                    start_fine_s = event_fine;
                    coarse_s     = COARSE_ONE;
                end else begin
                    start_fine_s = start_fine_r;
                end
            end
            S_WAIT_STOP: begin
                coarse_s = coarse_r + COARSE_ONE;
                if (event_valid) begin
                    result_interval_s = interval_calc_s;
                    result_timeout_s  = 1'b0;
                    result_valid_s    = 1'b1;
                end else if (coarse_r == TIMEOUT_VAL) begin
                    result_interval_s = {IW{1'b0}};
                    result_timeout_s  = 1'b1;
                    result_valid_s    = 1'b1;
                end else begin
                    result_valid_s    = 1'b0;
                end
            end
            S_DONE: begin
                // Events here are never STARTs, even in the accept cycle.
                if (event_valid) begin
                    dropped_s = sat_inc8(dropped_r);
                end else begin
                    dropped_s = dropped_r;
                end
                if (accept_s) begin
                    result_valid_s = 1'b0;
                end else begin
                    result_valid_s = result_valid_r;
                end
            end
            default: begin
                result_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coarse_r          <= {COARSE_W{1'b0}};
            start_fine_r      <= 6'd0;
            result_valid_r    <= 1'b0;
            result_interval_r <= {IW{1'b0}};
            result_timeout_r  <= 1'b0;
            busy_r            <= 1'b0;
            dropped_r         <= 8'd0;
        end else begin
            coarse_r          <= coarse_s;
            start_fine_r      <= start_fine_s;
            result_valid_r    <= result_valid_s;
            result_interval_r <= result_interval_s;
            result_timeout_r  <= result_timeout_s;
            busy_r            <= busy_s;
            dropped_r         <= dropped_s;
        end
    end

    assign result_valid    = result_valid_r;
    assign result_interval = result_interval_r;
    assign result_timeout  = result_timeout_r;
    assign busy            = busy_r;
    assign dropped_count   = dropped_r;

endmodule

// File: tb/tb_tdc_interval_calc.sv
// ---------------------------------------------------------------------------
// Testbench for tdc_interval_calc. Two instances with TIMEOUT_CYCLES=8:
// u_dut0 with AUTO_REARM=0, u_dut1 with AUTO_REARM=1. A timestamp-based
// reference model checks every output of both instances on every clock,
// alongside table-driven measurements and hand-written corner sequences.
// ---------------------------------------------------------------------------
module tb_tdc_interval_calc;

    localparam int CW = 16;
    localparam int IW = CW + 6;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          arm   [2];
    logic          ev    [2];
    logic [5:0]    fine  [2];
    logic          ready [2];
    logic          rv    [2];
    logic [IW-1:0] ri    [2];
    logic          rt    [2];
    logic          busy  [2];
    logic [7:0]    dc    [2];

    tdc_interval_calc #(.COARSE_W(CW), .TIMEOUT_CYCLES(TO), .AUTO_REARM(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm[0]), .event_valid(ev[0]), .event_fine(fine[0]),
        .result_valid(rv[0]), .result_ready(ready[0]), .result_interval(ri[0]),
        .result_timeout(rt[0]), .busy(busy[0]), .dropped_count(dc[0]));

    tdc_interval_calc #(.COARSE_W(CW), .TIMEOUT_CYCLES(TO), .AUTO_REARM(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm[1]), .event_valid(ev[1]), .event_fine(fine[1]),
        .result_valid(rv[1]), .result_ready(ready[1]), .result_interval(ri[1]),
        .result_timeout(rt[1]), .busy(busy[1]), .dropped_count(dc[1]));

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (timestamp based) ----------------
    // phase: 0 unarmed, 1 armed, 2 measuring, 3 holding a result
    longint cyc = 0;
    int     m_phase [2];
    longint m_start [2];
    int     m_sf    [2];
    bit     m_v     [2];
    longint m_i     [2];
    bit     m_t     [2];
    int     m_d     [2];

    task automatic model_step(input int k);
        longint d;
        if (!rst_n) begin
            m_phase[k] = 0; m_v[k] = 0; m_i[k] = 0; m_t[k] = 0; m_d[k] = 0;
        end else begin
            case (m_phase[k])
                0: if (arm[k]) m_phase[k] = 1;
                1: if (ev[k]) begin
                       m_start[k] = cyc; m_sf[k] = int'(fine[k]); m_phase[k] = 2;
                   end
                2: begin
                       d = cyc - m_start[k];
                       if (ev[k]) begin
                           m_i[k] = d * 64 + m_sf[k] - int'(fine[k]);
                           m_t[k] = 0; m_v[k] = 1; m_phase[k] = 3;
                       end else if (d == TO) begin
                           m_i[k] = 0; m_t[k] = 1; m_v[k] = 1; m_phase[k] = 3;
                       end
                   end
                3: begin
                       if (ev[k] && m_d[k] < 255) m_d[k]++;
                       if (ready[k]) begin
                           m_v[k] = 0;
                           m_phase[k] = (k == 1) ? 1 : 0;
                       end
                   end
                default: ;
            endcase
        end
    endtask

    // Model advances on each edge; outputs compared 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            cyc++;
            #1;
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("model_valid%0d", k), 32'(rv[k]), 32'(m_v[k]));
                    chk($sformatf("model_interval%0d", k), 32'(ri[k]), 32'(m_i[k]));
                    chk($sformatf("model_timeout%0d", k), 32'(rt[k]), 32'(m_t[k]));
                    chk($sformatf("model_busy%0d", k), 32'(busy[k]), 32'(m_phase[k] != 0));
                    chk($sformatf("model_dropped%0d", k), 32'(dc[k]), 32'(m_d[k]));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 1 unit after an edge and are held for one full cycle.
    task automatic cyc_in(input int k, input bit a, input bit e, input int f, input bit r);
        arm[k] = a; ev[k] = e; fine[k] = 6'(f); ready[k] = r;
        @(posedge clk);
        #1;
        arm[k] = 1'b0; ev[k] = 1'b0; ready[k] = 1'b0;
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) cyc_in(k, 1'b0, 1'b0, 0, 1'b0);
    endtask

    typedef struct {
        int sf;
        int ef;
        int d;
        int exp_int;
        bit exp_to;
        int stall;
    } vec_t;

    vec_t vecs[7];

    // One full measurement on u_dut0 from IDLE back to IDLE.
    task automatic measure(input vec_t v, input int idx);
        cyc_in(0, 1'b1, 1'b0, 0, 1'b0);
        chk($sformatf("v%0d_busy_armed", idx), 32'(busy[0]), 32'd1);
        cyc_in(0, 1'b0, 1'b1, v.sf, 1'b0);
        if (v.exp_to) begin
            idle(0, TO - 1);
            chk($sformatf("v%0d_no_early_valid", idx), 32'(rv[0]), 32'd0);
            idle(0, 1);
        end else begin
            idle(0, v.d - 1);
            chk($sformatf("v%0d_no_early_valid", idx), 32'(rv[0]), 32'd0);
            cyc_in(0, 1'b0, 1'b1, v.ef, 1'b0);
        end
        chk($sformatf("v%0d_valid", idx), 32'(rv[0]), 32'd1);
        chk($sformatf("v%0d_interval", idx), 32'(ri[0]), 32'(v.exp_int));
        chk($sformatf("v%0d_timeout", idx), 32'(rt[0]), 32'(v.exp_to));
        for (int s = 0; s < v.stall; s++) begin
            idle(0, 1);
            chk($sformatf("v%0d_stall_valid", idx), 32'(rv[0]), 32'd1);
            chk($sformatf("v%0d_stall_interval", idx), 32'(ri[0]), 32'(v.exp_int));
            chk($sformatf("v%0d_stall_busy", idx), 32'(busy[0]), 32'd1);
        end
        cyc_in(0, 1'b0, 1'b0, 0, 1'b1);
        chk($sformatf("v%0d_accept_valid", idx), 32'(rv[0]), 32'd0);
        chk($sformatf("v%0d_accept_busy", idx), 32'(busy[0]), 32'd0);
        chk($sformatf("v%0d_hold_interval", idx), 32'(ri[0]), 32'(v.exp_int));
    endtask

    initial begin
        vecs[0] = '{sf: 40, ef: 10, d: 3, exp_int: 222, exp_to: 1'b0, stall: 0};
        vecs[1] = '{sf: 0,  ef: 63, d: 1, exp_int: 1,   exp_to: 1'b0, stall: 5};
        vecs[2] = '{sf: 10, ef: 0,  d: TO, exp_int: 0,  exp_to: 1'b1, stall: 1};
        vecs[3] = '{sf: 33, ef: 50, d: 8, exp_int: 495, exp_to: 1'b0, stall: 0};
        vecs[4] = '{sf: 63, ef: 0,  d: 8, exp_int: 575, exp_to: 1'b0, stall: 2};
        vecs[5] = '{sf: 5,  ef: 5,  d: 2, exp_int: 128, exp_to: 1'b0, stall: 0};
        vecs[6] = '{sf: 0,  ef: 0,  d: 7, exp_int: 448, exp_to: 1'b0, stall: 1};

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            arm[k] = 1'b0; ev[k] = 1'b0; fine[k] = 6'd0; ready[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_valid", 32'(rv[k]), 32'd0);
            chk("reset_interval", 32'(ri[k]), 32'd0);
            chk("reset_timeout", 32'(rt[k]), 32'd0);
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_dropped", 32'(dc[k]), 32'd0);
        end
        rst_n = 1'b1;
        idle(0, 2);

        // Table-driven measurements.
        for (int i = 0; i < 7; i++) begin
            measure(vecs[i], i);
        end

        // arm together with an event: the event is not a START.
        cyc_in(0, 1'b1, 1'b1, 30, 1'b0);
        cyc_in(0, 1'b0, 1'b1, 50, 1'b0);
        cyc_in(0, 1'b0, 1'b1, 10, 1'b0);
        chk("arm_ev_valid", 32'(rv[0]), 32'd1);
        chk("arm_ev_interval", 32'(ri[0]), 32'd104);

        // Dropped events while holding the result.
        repeat (3) cyc_in(0, 1'b0, 1'b1, 0, 1'b0);
        chk("dropped_3", 32'(dc[0]), 32'd3);
        chk("dropped_result_stable", 32'(ri[0]), 32'd104);
        repeat (300) cyc_in(0, 1'b0, 1'b1, 0, 1'b0);
        chk("dropped_saturate", 32'(dc[0]), 32'd255);
        cyc_in(0, 1'b0, 1'b0, 0, 1'b1);
        repeat (5) cyc_in(0, 1'b0, 1'b1, 9, 1'b0);
        chk("idle_events_no_drop", 32'(dc[0]), 32'd255);
        chk("idle_events_no_busy", 32'(busy[0]), 32'd0);
        chk("idle_events_no_valid", 32'(rv[0]), 32'd0);

        // AUTO_REARM=1: accept returns to armed; accept-cycle event is dropped.
        cyc_in(1, 1'b1, 1'b0, 0, 1'b0);
        cyc_in(1, 1'b0, 1'b1, 40, 1'b0);
        cyc_in(1, 1'b0, 1'b1, 30, 1'b0);
        chk("rearm_first_interval", 32'(ri[1]), 32'd74);
        cyc_in(1, 1'b0, 1'b1, 7, 1'b1);
        chk("rearm_accept_valid", 32'(rv[1]), 32'd0);
        chk("rearm_busy", 32'(busy[1]), 32'd1);
        chk("rearm_dropped", 32'(dc[1]), 32'd1);
        cyc_in(1, 1'b0, 1'b1, 20, 1'b0);
        idle(1, 1);
        cyc_in(1, 1'b0, 1'b1, 4, 1'b0);
        chk("rearm_second_valid", 32'(rv[1]), 32'd1);
        chk("rearm_second_interval", 32'(ri[1]), 32'd144);
        cyc_in(1, 1'b0, 1'b0, 0, 1'b1);

        // Reset in the middle of a measurement.
        cyc_in(0, 1'b1, 1'b0, 0, 1'b0);
        cyc_in(0, 1'b0, 1'b1, 12, 1'b0);
        idle(0, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_dropped", 32'(dc[0]), 32'd0);
        chk("midrst_interval", 32'(ri[0]), 32'd0);
        chk("midrst_valid", 32'(rv[0]), 32'd0);
        cyc_in(0, 1'b0, 1'b1, 5, 1'b0);
        idle(0, TO + 2);
        chk("midrst_stop_ignored_valid", 32'(rv[0]), 32'd0);
        chk("midrst_stop_ignored_busy", 32'(busy[0]), 32'd0);

        // Randomized traffic on both instances, checked by the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < 2; k++) begin
                arm[k]   = ($urandom_range(0, 7) == 0);
                ev[k]    = ($urandom_range(0, 3) == 0);
                fine[k]  = 6'($urandom_range(0, 63));
                ready[k] = ($urandom_range(0, 1) == 1);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            arm[k] = 1'b0; ev[k] = 1'b0; ready[k] = 1'b0;
        end
        repeat (4) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
